// File: rtl/aes_round_key_cache.sv
// aes_round_key_cache: caches expanded AES round-key schedules and replays them forward or reversed.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_nk/in_slot/in_valid/in_first_flag/in_last_flag/in_rk
//                              round-key write stream from key expansion
//   rd_start/rd_slot/rd_reverse
//                              replay request (rd_start is a 1-cycle pulse)
//   out_busy                   replay in progress
//   out_valid/out_ready/out_first_flag/out_last_flag/out_rk
//                              replayed round-key stream
//   slot_valid                 per-slot complete-schedule flags
//   wr_err                     sticky malformed-write flag
//   rd_miss                    1-cycle pulse on a rejected rd_start
//   parity_err                 sticky read parity mismatch
// Optional feature: define RKC_PARITY_EN to store and check per-byte even parity.
module aes_round_key_cache #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   parameter int MAX_RK = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           in_nk,
   input  logic [SLOT_W-1:0]    in_slot,
   input  logic                 in_valid,
   input  logic                 in_first_flag,
   input  logic                 in_last_flag,
   input  logic [127:0]         in_rk,
   input  logic                 rd_start,
   input  logic [SLOT_W-1:0]    rd_slot,
   input  logic                 rd_reverse,
   output logic                 out_busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_first_flag,
   output logic                 out_last_flag,
   output logic [127:0]         out_rk,
   output logic [NUM_SLOTS-1:0] slot_valid,
   output logic                 wr_err,
   output logic                 rd_miss,
   output logic                 parity_err
);
   localparam int DEPTH = NUM_SLOTS * MAX_RK;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(MAX_RK + 1);

   typedef enum logic {WR_IDLE, WR_FILL} wr_state_t;
   typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

   function automatic logic [CW-1:0] nk_keys(input logic [1:0] nk);
      return (nk == 2'b00) ? CW'(11) : (nk == 2'b01) ? CW'(13) : CW'(15);
   endfunction

   logic [127:0] mem [DEPTH];
   logic [1:0]   slot_nk [NUM_SLOTS];

   wr_state_t         wr_state;
   logic [SLOT_W-1:0] wr_slot;
   logic [1:0]        wr_nk;
   logic [CW-1:0]     wr_cnt, wr_cnt_nx;
   logic              first_beat, nk_bad, first_ok, fill_beat, wr_en;
   logic [AW-1:0]     wr_addr;

   rd_state_t         rd_state;
   logic [SLOT_W-1:0] rd_slot_q;
   logic              rd_rev;
   logic [CW-1:0]     rd_cnt, rd_n, n0, idx;
   logic              start_ok, abort, o_adv, m_adv, issue, rd_en;
   logic [AW-1:0]     rd_addr;
   logic              m_valid, m_first, m_last;
   logic [127:0]      m_rk;

   assign first_beat = in_valid & in_first_flag;
   assign nk_bad     = in_nk == 2'b10;
   assign first_ok   = first_beat & !nk_bad;
   assign fill_beat  = in_valid & !in_first_flag & (wr_state == WR_FILL);
   assign wr_en      = first_ok | fill_beat;
   assign wr_cnt_nx  = wr_cnt + CW'(1);
   assign wr_addr    = first_ok ? AW'(in_slot * MAX_RK) : AW'(wr_slot * MAX_RK + wr_cnt);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_state   <= WR_IDLE;
         wr_slot    <= '0;
         wr_nk      <= '0;
         wr_cnt     <= '0;
         slot_valid <= '0;
         wr_err     <= 1'b0;
         slot_nk    <= '{default: '0};
      end else if (first_beat & nk_bad) begin
         wr_err   <= 1'b1;
         wr_state <= WR_IDLE;
      end else if (first_ok) begin
         wr_slot             <= in_slot;
         wr_nk               <= in_nk;
         wr_cnt              <= CW'(1);
         slot_valid[in_slot] <= 1'b0;
         if (in_last_flag) begin
            wr_err   <= 1'b1;
            wr_state <= WR_IDLE;
         end else
            wr_state <= WR_FILL;
      end else if (fill_beat) begin
         wr_cnt <= wr_cnt_nx;
         if (in_last_flag) begin
            if (wr_cnt_nx == nk_keys(wr_nk)) begin
               slot_valid[wr_slot] <= 1'b1;
               slot_nk[wr_slot]    <= wr_nk;
            end else
               wr_err <= 1'b1;
            wr_state <= WR_IDLE;
         end else if (wr_cnt_nx == CW'(MAX_RK)) begin
            wr_err   <= 1'b1;
            wr_state <= WR_IDLE;
         end
      end

   // A replay is started by issuing its first read in the same edge that
   // accepts rd_start, which gives the two-cycle start-to-valid latency.
   // rd_cnt counts reads issued; the entry index is derived from it.
   assign n0       = nk_keys(slot_nk[rd_slot]);
   assign rd_n     = nk_keys(slot_nk[rd_slot_q]);
   assign abort    = (rd_state == RD_RUN) & first_ok & (in_slot == rd_slot_q);
   assign start_ok = rd_start & (rd_state == RD_IDLE) & slot_valid[rd_slot] & !(first_ok & (in_slot == rd_slot));
   assign o_adv    = !out_valid | out_ready;
   assign m_adv    = !m_valid | o_adv;
   assign issue    = (rd_state == RD_RUN) & (rd_cnt != rd_n) & m_adv & !abort;
   assign rd_en    = start_ok | issue;
   assign idx      = start_ok ? (rd_reverse ? n0 - CW'(1) : '0) : (rd_rev ? rd_n - CW'(1) - rd_cnt : rd_cnt);
   assign rd_addr  = AW'((start_ok ? rd_slot : rd_slot_q) * MAX_RK + idx);
   assign out_busy = rd_state == RD_RUN;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= in_rk;
      if (rd_en) m_rk <= mem[rd_addr];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_state       <= RD_IDLE;
         rd_slot_q      <= '0;
         rd_rev         <= 1'b0;
         rd_cnt         <= '0;
         m_valid        <= 1'b0;
         m_first        <= 1'b0;
         m_last         <= 1'b0;
         out_valid      <= 1'b0;
         out_first_flag <= 1'b0;
         out_last_flag  <= 1'b0;
         out_rk         <= '0;
         rd_miss        <= 1'b0;
      end else begin
         rd_miss <= rd_start & !start_ok;
         if (abort) begin
            rd_state       <= RD_IDLE;
            m_valid        <= 1'b0;
            out_valid      <= 1'b0;
            out_first_flag <= 1'b0;
            out_last_flag  <= 1'b0;
         end else begin
            if (start_ok) begin
               rd_state  <= RD_RUN;
               rd_slot_q <= rd_slot;
               rd_rev    <= rd_reverse;
               rd_cnt    <= CW'(1);
            end else if (issue)
               rd_cnt <= rd_cnt + CW'(1);
            if (rd_en) begin
               m_valid <= 1'b1;
               m_first <= start_ok;
               m_last  <= !start_ok & (rd_cnt == rd_n - CW'(1));
            end else if (o_adv)
               m_valid <= 1'b0;
            if (o_adv) begin
               out_valid      <= m_valid;
               out_first_flag <= m_valid & m_first;
               out_last_flag  <= m_valid & m_last;
               if (m_valid) out_rk <= m_rk;
            end
            if (out_valid & out_ready & out_last_flag) rd_state <= RD_IDLE;
         end
      end

`ifdef RKC_PARITY_EN
   logic [15:0] par_mem [DEPTH];
   logic [15:0] m_par;

   function automatic logic [15:0] byte_par(input logic [127:0] d);
      logic [15:0] p;
      for (int i = 0; i < 16; i++) p[i] = ^d[8*i +: 8];
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_addr] <= byte_par(in_rk);
      if (rd_en) m_par <= par_mem[rd_addr];
   end

   // Checked as a key moves into the output stage, i.e. when it is delivered.
   always_ff @(posedge clk or posedge rst)
      if (rst)
         parity_err <= 1'b0;
      else if (!abort & o_adv & m_valid & (byte_par(m_rk) != m_par))
         parity_err <= 1'b1;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_round_key_cache.sv
// tb_aes_round_key_cache: randomized scoreboard bench for aes_round_key_cache.
module tb_aes_round_key_cache;
   localparam int NS = 4;
   localparam int SW = 2;
   localparam int MR = 15;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [1:0]     in_nk = '0;
   logic [SW-1:0]  in_slot = '0;
   logic           in_valid = 1'b0;
   logic           in_first_flag = 1'b0;
   logic           in_last_flag = 1'b0;
   logic [127:0]   in_rk = '0;
   logic           rd_start = 1'b0;
   logic [SW-1:0]  rd_slot = '0;
   logic           rd_reverse = 1'b0;
   logic           out_busy, out_valid, out_first_flag, out_last_flag;
   logic           out_ready;
   logic [127:0]   out_rk;
   logic [NS-1:0]  slot_valid;
   logic           wr_err, rd_miss, parity_err;

   aes_round_key_cache #(.NUM_SLOTS(NS), .SLOT_W(SW), .MAX_RK(MR)) dut (
      .clk(clk), .rst(rst), .in_nk(in_nk), .in_slot(in_slot), .in_valid(in_valid),
      .in_first_flag(in_first_flag), .in_last_flag(in_last_flag), .in_rk(in_rk),
      .rd_start(rd_start), .rd_slot(rd_slot), .rd_reverse(rd_reverse), .out_busy(out_busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_first_flag(out_first_flag),
      .out_last_flag(out_last_flag), .out_rk(out_rk), .slot_valid(slot_valid),
      .wr_err(wr_err), .rd_miss(rd_miss), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [127:0] rk; logic first; logic last;} beat_t;

   beat_t        exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   int           ready_mode = 0;
   logic [127:0] model_mem [NS][MR];
   bit           model_valid [NS];
   int           model_n [NS];
   bit           model_err = 0;
   logic [127:0] wtmp [MR+2];

   task automatic check(string name, logic [130:0] act, logic [130:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int keys_of(logic [1:0] nk);
      return (nk == 2'b00) ? 11 : (nk == 2'b01) ? 13 : 15;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Consumer: ready pattern chosen by ready_mode (always, alternating, random).
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) out_ready = 1'b1;
         else if (ready_mode == 1) out_ready = ~out_ready;
         else out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on each handshake and checks held data is stable.
   initial begin
      bit    held_v;
      beat_t held, cur, e;
      held_v = 0;
      forever begin
         @(negedge clk);
         if (rst) held_v = 0;
         else begin
            cur = '{out_rk, out_first_flag, out_last_flag};
            if (held_v) check("hold_stable", 131'({out_valid, cur}), 131'({1'b1, held}));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("unexpected_out", 131'(cur), 131'(0) - 131'(1));
               else begin
                  e = exp_q.pop_front();
                  check("out_key", 131'(cur), 131'(e));
               end
            end
            held_v = out_valid && !out_ready;
            held = cur;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic beat(int slot, logic [1:0] nk, bit f, bit l, logic [127:0] d);
      in_valid = 1'b1;
      in_first_flag = f;
      in_last_flag = l;
      in_slot = SW'(slot);
      in_nk = nk;
      in_rk = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_first_flag = 1'b0;
      in_last_flag = 1'b0;
   endtask

   // Model of a whole write sequence of nb beats starting with first, ending with last.
   task automatic model_write(int slot, logic [1:0] nk, int nb);
      logic [NS-1:0] v;
      if (nk == 2'b10) model_err = 1;
      else begin
         model_valid[slot] = 0;
         if (nb == keys_of(nk)) begin
            model_valid[slot] = 1;
            model_n[slot] = nb;
            for (int i = 0; i < nb; i++) model_mem[slot][i] = wtmp[i];
         end else model_err = 1;
      end
      for (int i = 0; i < NS; i++) v[i] = model_valid[i];
      check("slot_valid", 131'(slot_valid), 131'(v));
      check("wr_err", 131'(wr_err), 131'(model_err));
   endtask

   task automatic write_seq(int slot, logic [1:0] nk, int nb, bit idx_data);
      for (int b = 0; b < nb; b++) begin
         wtmp[b] = idx_data ? 128'(b) : rand128();
         beat(slot, nk, b == 0, b == nb - 1, wtmp[b]);
      end
      model_write(slot, nk, nb);
   endtask

   task automatic replay(int slot, bit rev);
      int n, cyc, ix;
      if (model_valid[slot]) begin
         n = model_n[slot];
         for (int k = 0; k < n; k++) begin
            ix = rev ? n - 1 - k : k;
            exp_q.push_back('{model_mem[slot][ix], k == 0, k == n - 1});
         end
      end
      rd_slot = SW'(slot);
      rd_reverse = rev;
      rd_start = 1'b1;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      if (!model_valid[slot]) begin
         check("rd_miss_pulse", 131'({rd_miss, out_busy}), 131'(2'b10));
         @(posedge clk);
         #1;
         check("rd_miss_clear", 131'({rd_miss, out_busy}), 131'(0));
         return;
      end
      check("start_busy", 131'({out_busy, out_valid}), 131'(2'b10));
      @(posedge clk);
      #1;
      check("first_valid_lat2", 131'(out_valid), 131'(1));
      cyc = 0;
      while (out_busy && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (out_busy) check("replay_timeout", 131'(1), 131'(0));
      if (ready_mode == 0) check("no_bubbles", 131'(cyc), 131'(n));
      check("replay_drained", 131'(exp_q.size()), 131'(0));
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         model_valid[i] = 0;
         model_n[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 131'({out_busy, out_valid, out_first_flag, out_last_flag, out_rk, slot_valid, wr_err, rd_miss, parity_err}), 131'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      write_seq(2, 2'b00, 11, 1);
      ready_mode = 0;
      replay(2, 0);
      ready_mode = 1;
      replay(2, 1);
      ready_mode = 0;

      write_seq(0, 2'b11, 14, 0);
      replay(0, 0);
      write_seq(3, 2'b10, 11, 0);
      write_seq(3, 2'b00, 1, 0);

      write_seq(1, 2'b11, 15, 0);
      fork
         replay(1, 0);
         write_seq(3, 2'b01, 13, 0);
      join

      fork
         replay(2, 0);
         begin
            repeat (4) @(posedge clk);
            #1;
            rd_slot = SW'(3);
            rd_start = 1'b1;
            @(posedge clk);
            #1;
            rd_start = 1'b0;
            check("rd_miss_busy", 131'({rd_miss, out_busy}), 131'(2'b11));
         end
      join

      write_seq(2, 2'b11, 16, 0);
      write_seq(2, 2'b00, 11, 0);

      write_seq(0, 2'b01, 13, 0);
      for (int k = 0; k < 13; k++) exp_q.push_back('{model_mem[0][k], k == 0, k == 12});
      rd_slot = SW'(0);
      rd_reverse = 1'b0;
      rd_start = 1'b1;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      for (int b = 0; b < 11; b++) wtmp[b] = rand128();
      beat(0, 2'b00, 1, 0, wtmp[0]);
      check("abort_out", 131'({out_valid, out_busy, out_last_flag}), 131'(0));
      check("abort_slot_invalid", 131'(slot_valid[0]), 131'(0));
      check("abort_partial_delivery", 131'(exp_q.size() > 0 && exp_q.size() < 13), 131'(1));
      exp_q.delete();
      for (int b = 1; b < 11; b++) beat(0, 2'b00, 0, b == 10, wtmp[b]);
      model_write(0, 2'b00, 11);
      replay(0, 1);

      for (int it = 0; it < 10; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            int s, m;
            logic [1:0] nk;
            s = $urandom_range(0, NS - 1);
            m = $urandom_range(0, 2);
            nk = (m == 0) ? 2'b00 : (m == 1) ? 2'b01 : 2'b11;
            write_seq(s, nk, keys_of(nk), 0);
         end
         ready_mode = $urandom_range(0, 2);
         replay($urandom_range(0, NS - 1), 1'($urandom_range(0, 1)));
      end
      ready_mode = 0;

      for (int k = 0; k < 11; k++) exp_q.push_back('{model_mem[2][k], k == 0, k == 10});
      rd_slot = SW'(2);
      rd_reverse = 1'b0;
      rd_start = 1'b1;
      @(posedge clk);
      #1;
      rd_start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 131'({out_busy, out_valid, out_first_flag, out_last_flag, out_rk, slot_valid, wr_err, rd_miss, parity_err}), 131'(0));
      exp_q.delete();
      for (int i = 0; i < NS; i++) model_valid[i] = 0;
      model_err = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      replay(2, 0);
      write_seq(1, 2'b00, 11, 0);
      replay(1, 0);

`ifdef RKC_PARITY_EN
      check("parity_clean", 131'(parity_err), 131'(0));
      dut.mem[1*MR + 3][5] = ~dut.mem[1*MR + 3][5];
      model_mem[1][3][5] = ~model_mem[1][3][5];
      replay(1, 0);
      check("parity_err_set", 131'(parity_err), 131'(1));
`endif

      check("final_drained", 131'(exp_q.size()), 131'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
